// File: rtl/cordic_post_scale.sv
// CORDIC output stage: removes the rotation gain from x/y, undoes the upstream
// quadrant pre-rotation and delays z to match, as a 2-stage valid/ready pipeline.
module cordic_post_scale #(
  parameter int          WIDTH  = 32,
  parameter logic [31:0] K_GAIN = 32'h9B74EDA8,
  parameter bit          ROUND  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic [1:0]       quad_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam int PW = WIDTH + 33;
  localparam logic [PW-1:0] RND_C = ROUND ? {{(PW-32){1'b0}}, 1'b1, 31'b0} : '0;
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};

  logic adv;
  logic signed [PW-1:0] xe, ye, ke, px_next, py_next;
  logic signed [PW-1:0] px, py;
  logic [PW-1:0] rx, ry;
  logic [WIDTH-1:0] z1;
  logic [1:0] q1;
  logic v1;
  logic [WIDTH-1:0] sx, sy, x_next, y_next;
  logic unused_bits;

  // Held registers downstream never block a bubble, so adv depends only on the output side.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;

  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] v);
    if (v == MIN_V) return MAX_V;
    return -v;
  endfunction

  always_comb begin
    xe      = PW'($signed(x_in));
    ye      = PW'($signed(y_in));
    ke      = PW'($signed({1'b0, K_GAIN}));
    px_next = xe * ke;
    py_next = ye * ke;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= '0;
      py <= '0;
      z1 <= '0;
      q1 <= '0;
      v1 <= 1'b0;
    end else if (adv) begin
      px <= px_next;
      py <= py_next;
      z1 <= z_in;
      q1 <= quad_in;
      v1 <= in_valid;
    end
  end

  // Arithmetic shift by 32 of a product that always fits back into WIDTH bits.
  always_comb begin
    rx = px + RND_C;
    ry = py + RND_C;
    sx = rx[WIDTH+31:32];
    sy = ry[WIDTH+31:32];
  end

  assign unused_bits = ^{rx[PW-1:WIDTH+32], rx[31:0], ry[PW-1:WIDTH+32], ry[31:0]};

  always_comb begin
    x_next = sx;
    y_next = sy;
    case (q1)
      2'b01: begin
        x_next = neg_sat(sy);
        y_next = sx;
      end
      2'b10: begin
        x_next = sy;
        y_next = neg_sat(sx);
      end
      2'b11: begin
        x_next = neg_sat(sx);
        y_next = neg_sat(sy);
      end
      default: begin
        x_next = sx;
        y_next = sy;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      x_out     <= x_next;
      y_out     <= y_next;
      z_out     <= z1;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_cordic_post_scale.sv
// Directed bench for cordic_post_scale: vector table, backpressure stream,
// mid-stream reset and a saturating-negation instance.
module tb_cordic_post_scale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x_in, y_in, z_in, x_out, y_out, z_out;
  logic [1:0]  quad_in;

  logic        s_in_valid, s_in_ready, s_out_valid;
  logic [31:0] s_x_in, s_y_in, s_x_out, s_y_out, s_z_out;
  logic [1:0]  s_quad;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cordic_post_scale dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .quad_in(quad_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_post_scale #(.WIDTH(32), .K_GAIN(32'hFFFFFFFF), .ROUND(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .x_in(s_x_in), .y_in(s_y_in), .z_in(32'h0), .quad_in(s_quad),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .x_out(s_x_out), .y_out(s_y_out), .z_out(s_z_out)
  );

  typedef struct {
    logic [31:0] x, y, z;
    logic [1:0]  q;
    logic [31:0] ex, ey;
  } vec_t;

  vec_t vt[10];
  logic pat[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    x_in    = vt[i].x;
    y_in    = vt[i].y;
    z_in    = vt[i].z;
    quad_in = vt[i].q;
  endtask

  initial begin
    int n, idx, got;
    logic held, hv;
    logic [31:0] hx, hy, hz;

    vt[0] = '{32'h40000000, 32'h0,        32'h1234, 2'b00, 32'h26DD3B6A, 32'h0};
    vt[1] = '{32'hC0000000, 32'h0,        32'h1,    2'b00, 32'hD922C496, 32'h0};
    vt[2] = '{32'h00000001, 32'h0,        32'h2,    2'b00, 32'h00000001, 32'h0};
    vt[3] = '{32'hFFFFFFFF, 32'h0,        32'h3,    2'b00, 32'hFFFFFFFF, 32'h0};
    vt[4] = '{32'h40000000, 32'h0,        32'h4,    2'b01, 32'h0,        32'h26DD3B6A};
    vt[5] = '{32'h40000000, 32'h0,        32'h5,    2'b11, 32'hD922C496, 32'h0};
    vt[6] = '{32'h40000000, 32'h0,        32'h6,    2'b10, 32'h0,        32'hD922C496};
    vt[7] = '{32'h0,        32'h40000000, 32'h7,    2'b01, 32'hD922C496, 32'h0};
    vt[8] = '{32'h0,        32'hC0000000, 32'h8,    2'b10, 32'hD922C496, 32'h0};
    vt[9] = '{32'h00000001, 32'hFFFFFFFF, 32'h9,    2'b11, 32'hFFFFFFFF, 32'h00000001};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0; quad_in = '0;
    s_in_valid = 1'b0; s_x_in = '0; s_y_in = '0; s_quad = '0;
    #3;
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset in_ready", {31'b0, in_ready}, 32'h0);
    check("reset x_out", x_out, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single samples, one at a time
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(i);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d latency", i), n, 32'd1);
      if (!out_valid) begin
        n_vec++; n_miss++;
        $display("FAIL vec%0d timeout: out_valid stayed 0", i);
      end else begin
        check($sformatf("vec%0d x", i), x_out, vt[i].ex);
        check($sformatf("vec%0d y", i), y_out, vt[i].ey);
        check($sformatf("vec%0d z", i), z_out, vt[i].z);
      end
    end

    // Backpressure stream of 8 samples
    idx = 0; got = 0; held = 1'b0; hv = 1'b0; hx = '0; hy = '0; hz = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 8];
      in_valid  = (idx < 8);
      if (idx < 8) drive(idx);
      #1;
      check("stream in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (held) begin
        check("stall out_valid", {31'b0, out_valid}, {31'b0, hv});
        check("stall x", x_out, hx);
        check("stall y", y_out, hy);
        check("stall z", z_out, hz);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d x", got), x_out, vt[got].ex);
        check($sformatf("stream%0d y", got), y_out, vt[got].ey);
        check($sformatf("stream%0d z", got), z_out, vt[got].z);
        got++;
      end
      held = out_valid && !out_ready;
      hv = out_valid; hx = x_out; hy = y_out; hz = z_out;
      if (in_valid && in_ready) idx++;
    end
    check("stream count", got, 32'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with two samples in flight
    drive(0); in_valid = 1'b1;
    @(negedge clk);
    drive(1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", {31'b0, out_valid}, 32'h0);
    check("midreset x", x_out, 32'h0);
    check("midreset y", y_out, 32'h0);
    check("midreset z", z_out, 32'h0);
    check("midreset in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("postreset idle", {31'b0, out_valid}, 32'h0);
    drive(5); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("postreset lat1", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("postreset lat2", {31'b0, out_valid}, 32'h1);
    check("postreset x", x_out, 32'hD922C496);
    check("postreset z", z_out, 32'h5);
    @(negedge clk);
    check("postreset drained", {31'b0, out_valid}, 32'h0);

    // Saturating negation of -2^31
    s_x_in = 32'h80000000; s_y_in = 32'h0; s_quad = 2'b11; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sat valid", {31'b0, s_out_valid}, 32'h1);
    check("sat x", s_x_out, 32'h7FFFFFFF);
    check("sat y", s_y_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cordic_post_scale.md
Name: cordic_post_scale

Overview:
- Output stage that sits directly downstream of the last shift-accumulate iteration of the CORDIC rotation pipeline.
- Removes the CORDIC gain by multiplying x and y by K ≈ 0.607252935.
- Undoes the quadrant pre-rotation that was applied before the first iteration, and passes z through unchanged.
- Two-stage pipeline with a valid/ready handshake, so downstream backpressure stalls the datapath without losing samples.

Parameters:
- WIDTH, 32, datapath width of x/y/z (two's complement).
- K_GAIN, 32'h9B74EDA8, gain constant as unsigned Q0.32 (0.607252935 × 2^32).
- ROUND, 1, 1 = round half up (add 2^31 before truncation); 0 = truncate toward −inf.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, x_in/y_in/z_in/quad_in are valid this cycle.
- in_ready, output, 1, stage accepts input this cycle.
- x_in, input, WIDTH, x from final iteration (signed).
- y_in, input, WIDTH, y from final iteration (signed).
- z_in, input, WIDTH, residual angle (signed).
- quad_in, input, 2, pre-rotation applied upstream: 00 none, 01 +90°, 10 −90°, 11 180°.
- out_valid, output, 1, output data valid.
- out_ready, input, 1, downstream accepts output.
- x_out, output, WIDTH, gain-corrected, quadrant-corrected x.
- y_out, output, WIDTH, gain-corrected, quadrant-corrected y.
- z_out, output, WIDTH, z delayed to match.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits, out_valid, x_out, y_out and z_out go to 0. in_ready is 0 while reset is asserted. A transaction in flight when reset asserts is discarded, with no partial output.
- Advance condition: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid/out_ready only, never from in_valid).
- Accept: input is taken when in_valid && in_ready. All registers hold when adv = 0.
- Stage 1, on adv:
  - px = signed(x_in) × {1'b0, K_GAIN}, 65-bit signed; py likewise from y_in.
  - z1 = z_in, q1 = quad_in, v1 = in_valid.
- Stage 2, on adv:
  - sx = (px + (ROUND ? 2^31 : 0)) >>> 32, low WIDTH bits; sy likewise.
  - Quadrant correction:
    - 00: x_out = sx, y_out = sy.
    - 01: x_out = −sy, y_out = sx.
    - 10: x_out = sy, y_out = −sx.
    - 11: x_out = −sx, y_out = −sy.
  - Negation saturates: −(−2^(WIDTH−1)) gives 2^(WIDTH−1)−1.
  - z_out = z1, out_valid = v1.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, x_out/y_out/z_out/out_valid are held stable and in_ready = 0.
- Bubbles: an empty stage (v1 = 0) still advances. Bubbles are not collapsed while stalled.
- Simultaneous events: out_ready and in_valid in the same cycle with out_valid = 1 completes one transfer out and one accept in that cycle.
- Data ports are don't-care when the matching valid is 0. The bench must not check them.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with 2 samples in flight → out_valid = 0 and outputs = 0 immediately (no clock needed). After release, the first out_valid appears 2 cycles after the first new accept.
- Gain, single sample: x_in = 32'h40000000, y_in = 0, z_in = 32'h00001234, quad = 00 → after 2 cycles x_out = 32'h26DD3B6A, y_out = 0, z_out = 32'h00001234.
- Signed and rounding:
  - x_in = 32'hC0000000 → x_out = 32'hD922C496.
  - x_in = 1 → x_out = 1.
  - x_in = 32'hFFFFFFFF → x_out = 32'hFFFFFFFF (ROUND = 1).
- Quadrant correction, x_in = 32'h40000000, y_in = 0:
  - quad 01 → x_out = 0, y_out = 32'h26DD3B6A.
  - quad 11 → x_out = 32'hD922C496, y_out = 0.
  - quad 10 → x_out = 0, y_out = 32'hD922C496.
- Backpressure: stream 8 samples with out_ready pattern 1,0,0,1,0,1,1,… → in_ready mirrors the stalls. All 8 samples emerge in order with correct values, none duplicated or dropped, and outputs stay stable during every stall cycle.
- Saturation: ROUND = 0, K_GAIN = 32'hFFFFFFFF, x_in = 32'h80000000, quad 11 → x_out = 32'h7FFFFFFF (saturated negation of −2^31).
